// File: rtl/v_registers_pipe.sv
// Parametrised register pipeline: DEPTH stages of WIDTH-bit data with async
// preset, clock enable, sync clear, per-stage valid and a registered occupancy.
module v_registers_pipe #(
  parameter int unsigned          WIDTH = 4,
  parameter int unsigned          DEPTH = 3,
  parameter logic [WIDTH-1:0]     INIT  = '1
) (
  input  logic                         C,
  input  logic                         PRE,
  input  logic                         CE,
  input  logic                         CLR,
  input  logic [WIDTH-1:0]             D,
  input  logic                         DV,
  output logic [WIDTH-1:0]             Q,
  output logic                         QV,
  output logic [WIDTH*DEPTH-1:0]       TAPS,
  output logic [$clog2(DEPTH+1)-1:0]   OCC
);

  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [OW-1:0]    occ;
  logic [OW-1:0]    occ_next;

  // Beat entering minus beat leaving; bounded to 0..DEPTH by construction.
  assign occ_next = occ + OW'(DV) - OW'(valid[DEPTH-1]);

  // NOTE: the stage array is a bank of flops, not a RAM, so resetting every
  // entry is legal and intended; sequential state uses non-blocking updates so
  // each stage samples its predecessor's pre-edge value.
  always_ff @(posedge C or posedge PRE) begin
    if (PRE) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= INIT;
      valid <= '0;
      occ   <= '0;
    end else if (CLR) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= INIT;
      valid <= '0;
      occ   <= '0;
    end else if (CE) begin
      stage[0] <= D;
      valid[0] <= DV;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
        valid[k] <= valid[k-1];
      end
      occ <= occ_next;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_taps
    assign TAPS[g*WIDTH +: WIDTH] = stage[g];
  end

  assign Q   = stage[DEPTH-1];
  assign QV  = valid[DEPTH-1];
  assign OCC = occ;

endmodule

// File: tb/tb_v_registers_pipe.sv
// Directed bench for v_registers_pipe (WIDTH=4, DEPTH=3, INIT=4'hF) with
// hand-computed expectations.
module tb_v_registers_pipe;

  logic        C = 1'b0;
  logic        PRE, CE, CLR, DV;
  logic [3:0]  D;
  logic [3:0]  Q;
  logic        QV;
  logic [11:0] TAPS;
  logic [1:0]  OCC;

  int n_checks = 0;
  int n_pass   = 0;

  v_registers_pipe #(.WIDTH(4), .DEPTH(3), .INIT(4'hF)) dut (
    .C(C), .PRE(PRE), .CE(CE), .CLR(CLR), .D(D), .DV(DV),
    .Q(Q), .QV(QV), .TAPS(TAPS), .OCC(OCC)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] q, input logic qv,
                            input logic [1:0] occ);
    check({tag, ".q"},   Q,   q);
    check({tag, ".qv"},  QV,  qv);
    check({tag, ".occ"}, OCC, occ);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    PRE = 1'b0; CE = 1'b0; CLR = 1'b0; DV = 1'b0; D = 4'h0;

    // 1: async preset between edges takes effect without a clock
    #2 PRE = 1'b1;
    #1;
    expect_out("reset", 4'hF, 1'b0, 2'd0);
    check("reset.taps", TAPS, 12'hFFF);
    step();
    check("reset_hold.taps", TAPS, 12'hFFF);
    PRE = 1'b0;

    // 2: stream 1..4, then drain
    CE = 1'b1; DV = 1'b1;
    D = 4'h1; step(); expect_out("stream1", 4'hF, 1'b0, 2'd1);
    D = 4'h2; step(); expect_out("stream2", 4'hF, 1'b0, 2'd2);
    D = 4'h3; step(); expect_out("stream3", 4'h1, 1'b1, 2'd3);
    D = 4'h4; step(); expect_out("stream4", 4'h2, 1'b1, 2'd3);
    check("stream4.taps", TAPS, 12'h234);
    DV = 1'b0; D = 4'h0;
    step(); expect_out("drain1", 4'h3, 1'b1, 2'd2);
    step(); expect_out("drain2", 4'h4, 1'b1, 2'd1);
    step(); expect_out("drain3", 4'h0, 1'b0, 2'd0);

    // 3: stall with CE=0 adds no latency
    D = 4'h5; DV = 1'b1; step();
    check("stall_load.taps", TAPS, 12'h005);
    CE = 1'b0; DV = 1'b0; D = 4'hE;
    step(); check("stall1.taps", TAPS, 12'h005); check("stall1.occ", OCC, 2'd1);
    step(); check("stall2.taps", TAPS, 12'h005); check("stall2.qv", QV, 1'b0);
    CE = 1'b1; D = 4'h0;
    step(); expect_out("unstall1", 4'h0, 1'b0, 2'd1);
    step(); expect_out("unstall2", 4'h5, 1'b1, 2'd1);
    check("unstall2.taps", TAPS, 12'h500);

    // 4: bubbles A(v) B(nv) C(v)
    D = 4'hA; DV = 1'b1; step(); expect_out("bub1", 4'h0, 1'b0, 2'd1);
    D = 4'hB; DV = 1'b0; step(); expect_out("bub2", 4'h0, 1'b0, 2'd1);
    D = 4'hC; DV = 1'b1; step(); expect_out("bub3", 4'hA, 1'b1, 2'd2);
    D = 4'h0; DV = 1'b0; step(); expect_out("bub4", 4'hB, 1'b0, 2'd1);
    step(); expect_out("bub5", 4'hC, 1'b1, 2'd1);
    step(); expect_out("bub6", 4'h0, 1'b0, 2'd0);

    // 5: sync clear beats CE=0 and drops a simultaneous valid beat
    DV = 1'b1;
    D = 4'h1; step();
    D = 4'h2; step();
    D = 4'h3; step();
    check("fill.occ", OCC, 2'd3);
    check("fill.taps", TAPS, 12'h123);
    CLR = 1'b1; CE = 1'b0; D = 4'h9;
    step();
    expect_out("clear", 4'hF, 1'b0, 2'd0);
    check("clear.taps", TAPS, 12'hFFF);
    CLR = 1'b0; CE = 1'b1; DV = 1'b0; D = 4'h0;

    // 6: mid-stream preset pulse, then fresh latency
    DV = 1'b1;
    D = 4'h6; step();
    D = 4'h8; step();
    check("mid.occ", OCC, 2'd2);
    check("mid.taps", TAPS, 12'hF68);
    DV = 1'b0;
    #2 PRE = 1'b1;
    #1;
    expect_out("mid_pre", 4'hF, 1'b0, 2'd0);
    check("mid_pre.taps", TAPS, 12'hFFF);
    #1 PRE = 1'b0;
    D = 4'h7; DV = 1'b1; step(); expect_out("post1", 4'hF, 1'b0, 2'd1);
    D = 4'h0; DV = 1'b0; step(); expect_out("post2", 4'hF, 1'b0, 2'd1);
    step(); expect_out("post3", 4'h7, 1'b1, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
